// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter stage of the single-cycle CPU. Holds the PC and presents it
//   to the instruction ROM. It computes the next PC from one of four sources:
//   sequential, branch, jr or jump. It stops when the halt opcode is fetched,
//   and it stops when the next PC would be illegal. It also counts accepted PC
//   advances.
//
// Ports
//   CLK          in   1   clock, rising edge
//   Reset        in   1   asynchronous, active-low reset
//   PCWre        in   1   1 = PC may advance this cycle, 0 = stall
//   PCSrc        in   2   00 PC+4, 01 branch, 10 jr, 11 jump
//   Immediate    in   32  sign-extended branch offset in words
//   JumpAddr     in   26  j/jal target field
//   RegJumpAddr  in   32  rs value for jr
//   Instruction  in   32  ROM word at IAddr (combinational read)
//   IAddr        out  32  current PC, byte address
//   InsMemRW     out  1   fetch enable
//   PC4          out  32  IAddr+4 (jal link value)
//   Halted       out  1   sticky, halt opcode reached
//   AddrFault    out  1   sticky, illegal next PC rejected
//   InstCount    out  32  PC advances since reset
//
// state    | meaning
// ST_BOOT  | first cycle after reset release, enables fetch, PC held
// ST_RUN   | normal fetch, PC advances when PCWre=1
// ST_HALT  | halt opcode committed, everything frozen until reset
// ST_FAULT | illegal next PC rejected, everything frozen until reset

module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]  HALT_OPCODE = 6'b111111,
   parameter int unsigned IMEM_WORDS  = 128
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        PCWre,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] Immediate,
   input  logic [25:0] JumpAddr,
   input  logic [31:0] RegJumpAddr,
   input  logic [31:0] Instruction,
   output logic [31:0] IAddr,
   output logic        InsMemRW,
   output logic [31:0] PC4,
   output logic        Halted,
   output logic        AddrFault,
   output logic [31:0] InstCount
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // This width holds the byte limit even when the ROM fills the whole 32-bit space.
   localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] count_q, count_d;
   logic        halted_q, halted_d;
   logic        fault_q, fault_d;
   logic        fetch_q, fetch_d;

   logic [31:0] pc4;
   logic [31:0] imm_bytes;
   logic [31:0] npc;
   logic        npc_illegal;
   logic        unused_instr_bits;

   // Only the opcode field matters here. The rest of the word belongs to the decoder.
   assign unused_instr_bits = ^Instruction[25:0];

   assign pc4       = pc_q + 32'd4;
   assign imm_bytes = Immediate << 2;

   always_comb begin
      npc = pc4;
      unique case (PCSrc)
         2'b00:   npc = pc4;
         2'b01:   npc = pc4 + imm_bytes;
         2'b10:   npc = RegJumpAddr;
         default: npc = {pc4[31:28], JumpAddr, 2'b00};
      endcase
   end

   assign npc_illegal = (npc[1:0] != 2'b00) || ({1'b0, npc} >= PC_LIMIT);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      fetch_d  = fetch_q;
      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            fetch_d = 1'b1;
         end
         ST_RUN: begin
            // A stalled cycle commits nothing, so the halt opcode is not checked either.
            if (PCWre) begin
               if (Instruction[31:26] == HALT_OPCODE) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
                  fetch_d  = 1'b0;
               end else if (npc_illegal) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
                  fetch_d = 1'b0;
               end else begin
                  pc_d    = npc;
                  count_d = count_q + 32'd1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         count_q  <= 32'd0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
         fetch_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
         fetch_q  <= fetch_d;
      end
   end

   assign IAddr     = pc_q;
   assign PC4       = pc4;
   assign InsMemRW  = fetch_q;
   assign Halted    = halted_q;
   assign AddrFault = fault_q;
   assign InstCount = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit. It first runs a fixed vector table through the
// basic flows: sequential, branch, jump, jr, stall and halt. Next it runs
// short hand-written sequences for faults and for asynchronous reset. Last it
// runs a long random run that is compared against an arithmetic reference model.

module tb_pc_fetch_unit;

   localparam logic [31:0] HALT_INS = 32'hFC00_0000;
   localparam int unsigned ROM_BYTES = 128 * 4;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        PCWre = 1'b0;
   logic [1:0]  PCSrc = 2'b00;
   logic [31:0] Immediate = 32'd0;
   logic [25:0] JumpAddr = 26'd0;
   logic [31:0] RegJumpAddr = 32'd0;
   logic [31:0] Instruction = 32'd0;
   logic [31:0] IAddr;
   logic        InsMemRW;
   logic [31:0] PC4;
   logic        Halted;
   logic        AddrFault;
   logic [31:0] InstCount;

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   pc_fetch_unit dut (
      .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
      .Immediate(Immediate), .JumpAddr(JumpAddr), .RegJumpAddr(RegJumpAddr),
      .Instruction(Instruction), .IAddr(IAddr), .InsMemRW(InsMemRW),
      .PC4(PC4), .Halted(Halted), .AddrFault(AddrFault), .InstCount(InstCount)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the architectural PC and counters, advanced one committed edge at a time.
   logic [31:0] m_pc, m_cnt;
   logic        m_halt, m_fault, m_fetch, m_started;

   task automatic model_reset();
      m_pc = 32'd0; m_cnt = 32'd0;
      m_halt = 1'b0; m_fault = 1'b0; m_fetch = 1'b0; m_started = 1'b0;
   endtask

   task automatic model_edge();
      logic [31:0] npc;
      if (!m_started) begin
         m_started = 1'b1;
         m_fetch = 1'b1;
         return;
      end
      if (m_halt || m_fault || !PCWre) return;
      if (Instruction[31:26] == 6'h3F) begin
         m_halt = 1'b1; m_fetch = 1'b0;
         return;
      end
      case (PCSrc)
         2'd0:    npc = m_pc + 32'd4;
         2'd1:    npc = m_pc + 32'd4 + Immediate * 32'd4;
         2'd2:    npc = RegJumpAddr;
         default: npc = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, JumpAddr} * 32'd4);
      endcase
      if ((npc % 32'd4) != 32'd0 || npc >= ROM_BYTES) begin
         m_fault = 1'b1; m_fetch = 1'b0;
         return;
      end
      m_pc = npc;
      m_cnt = m_cnt + 32'd1;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_iaddr"}, IAddr, m_pc);
      check({tag, "_pc4"}, PC4, m_pc + 32'd4);
      check({tag, "_cnt"}, InstCount, m_cnt);
      check({tag, "_halted"}, {31'd0, Halted}, {31'd0, m_halt});
      check({tag, "_fault"}, {31'd0, AddrFault}, {31'd0, m_fault});
      check({tag, "_insmemrw"}, {31'd0, InsMemRW}, {31'd0, m_fetch});
   endtask

   // Call this task at posedge+1. It applies one edge with the current inputs and checks the result.
   task automatic tick(input string tag);
      model_edge();
      @(posedge CLK);
      #1;
      check_model(tag);
   endtask

   // Call this task at posedge+1. It asserts reset between edges, holds reset across one edge, then releases it.
   task automatic do_reset();
      Reset = 1'b0;
      #2;
      model_reset();
      check_model("rst");
      @(posedge CLK);
      #1;
      check_model("rst_hold");
      Reset = 1'b1;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  src;
      logic [31:0] imm;
      logic [25:0] ja;
      logic [31:0] rja;
      logic [31:0] ins;
      logic [31:0] e_pc;
      logic [31:0] e_cnt;
      logic        e_halt;
      logic        e_fetch;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic we, input logic [1:0] src, input logic [31:0] imm,
                      input logic [25:0] ja, input logic [31:0] rja, input logic [31:0] ins,
                      input logic [31:0] e_pc, input logic [31:0] e_cnt,
                      input logic e_halt, input logic e_fetch);
      vec_t v;
      v.we = we; v.src = src; v.imm = imm; v.ja = ja; v.rja = rja; v.ins = ins;
      v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_halt = e_halt; v.e_fetch = e_fetch;
      tbl.push_back(v);
   endtask

   initial begin
      // The vector table starts from reset release. Row 0 is the BOOT edge.
      add(1'b1, 2'd0, 32'd0, 26'd0, 32'd0, 32'd0, 32'h00, 32'd0, 1'b0, 1'b1);
      add(1'b1, 2'd0, 32'd0, 26'd0, 32'd0, 32'd0, 32'h04, 32'd1, 1'b0, 1'b1);
      add(1'b1, 2'd0, 32'd0, 26'd0, 32'd0, 32'd0, 32'h08, 32'd2, 1'b0, 1'b1);
      add(1'b1, 2'd0, 32'd0, 26'd0, 32'd0, 32'd0, 32'h0C, 32'd3, 1'b0, 1'b1);
      add(1'b1, 2'd0, 32'd0, 26'd0, 32'd0, 32'd0, 32'h10, 32'd4, 1'b0, 1'b1);
      add(1'b1, 2'd1, 32'hFFFF_FFFE, 26'd0, 32'd0, 32'd0, 32'h0C, 32'd5, 1'b0, 1'b1);
      add(1'b1, 2'd3, 32'd0, 26'h1F, 32'd0, 32'd0, 32'h7C, 32'd6, 1'b0, 1'b1);
      add(1'b1, 2'd2, 32'd0, 26'd0, 32'h20, 32'd0, 32'h20, 32'd7, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         add(1'b0, 2'd0, 32'd0, 26'd0, 32'd0, HALT_INS, 32'h20, 32'd7, 1'b0, 1'b1);
      add(1'b1, 2'd0, 32'd0, 26'd0, 32'd0, 32'd0, 32'h24, 32'd8, 1'b0, 1'b1);
      add(1'b1, 2'd2, 32'd0, 26'd0, 32'h18, 32'd0, 32'h18, 32'd9, 1'b0, 1'b1);
      add(1'b1, 2'd0, 32'd0, 26'd0, 32'd0, HALT_INS, 32'h18, 32'd9, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++)
         add(1'b1, 2'd0, 32'd0, 26'd0, 32'd0, 32'd0, 32'h18, 32'd9, 1'b1, 1'b0);

      #2;
      check("por_iaddr", IAddr, 32'h0);
      check("por_pc4", PC4, 32'h4);
      check("por_insmemrw", {31'd0, InsMemRW}, 32'd0);
      check("por_cnt", InstCount, 32'd0);
      check("por_flags", {30'd0, Halted, AddrFault}, 32'd0);
      @(posedge CLK);
      #1;
      check("por_hold_iaddr", IAddr, 32'h0);
      check("por_hold_insmemrw", {31'd0, InsMemRW}, 32'd0);
      Reset = 1'b1;

      foreach (tbl[i]) begin
         PCWre = tbl[i].we; PCSrc = tbl[i].src; Immediate = tbl[i].imm;
         JumpAddr = tbl[i].ja; RegJumpAddr = tbl[i].rja; Instruction = tbl[i].ins;
         @(posedge CLK);
         #1;
         check($sformatf("tbl%0d_iaddr", i), IAddr, tbl[i].e_pc);
         check($sformatf("tbl%0d_pc4", i), PC4, tbl[i].e_pc + 32'd4);
         check($sformatf("tbl%0d_cnt", i), InstCount, tbl[i].e_cnt);
         check($sformatf("tbl%0d_halted", i), {31'd0, Halted}, {31'd0, tbl[i].e_halt});
         check($sformatf("tbl%0d_fault", i), {31'd0, AddrFault}, 32'd0);
         check($sformatf("tbl%0d_insmemrw", i), {31'd0, InsMemRW}, {31'd0, tbl[i].e_fetch});
      end

      // First case: the top legal word, then a misaligned jr. After the fault, a halt opcode must not set Halted.
      PCWre = 1'b1; PCSrc = 2'd0; Instruction = 32'd0;
      do_reset();
      tick("f1_boot");
      PCSrc = 2'd2; RegJumpAddr = 32'h1FC;
      tick("f1_top");
      check("f1_top_iaddr", IAddr, 32'h1FC);
      RegJumpAddr = 32'h202;
      tick("f1_mis");
      check("f1_mis_fault", {31'd0, AddrFault}, 32'd1);
      check("f1_mis_iaddr", IAddr, 32'h1FC);
      check("f1_mis_halted", {31'd0, Halted}, 32'd0);
      PCSrc = 2'd0; Instruction = HALT_INS;
      tick("f1_frozen0");
      Instruction = 32'd0;
      tick("f1_frozen1");
      check("f1_frozen_halted", {31'd0, Halted}, 32'd0);

      // Second case: the first illegal byte address after the ROM, reached through jr.
      do_reset();
      tick("f2_boot");
      PCSrc = 2'd2; RegJumpAddr = 32'h200;
      tick("f2_oor");
      check("f2_oor_fault", {31'd0, AddrFault}, 32'd1);
      check("f2_oor_iaddr", IAddr, 32'h0);
      check("f2_oor_halted", {31'd0, Halted}, 32'd0);

      // Third case: a branch from PC 0 that wraps below zero must fault.
      do_reset();
      tick("f3_boot");
      PCSrc = 2'd1; Immediate = 32'hFFFF_FFFF;
      tick("f3_self");
      check("f3_self_cnt", InstCount, 32'd1);
      Immediate = 32'hFFFF_FFFE;
      tick("f3_wrap");
      check("f3_wrap_fault", {31'd0, AddrFault}, 32'd1);

      // Reset is asserted between edges while the unit is running at PC 0x40.
      do_reset();
      PCSrc = 2'd0;
      tick("ar_boot");
      PCSrc = 2'd2; RegJumpAddr = 32'h40;
      tick("ar_jr");
      check("ar_at40", IAddr, 32'h40);
      PCSrc = 2'd0;
      #3;
      Reset = 1'b0;
      #1;
      model_reset();
      check("ar_iaddr", IAddr, 32'h0);
      check("ar_cnt", InstCount, 32'd0);
      check("ar_insmemrw", {31'd0, InsMemRW}, 32'd0);
      @(posedge CLK);
      #1;
      Reset = 1'b1;
      tick("ar_boot2");
      tick("ar_run2");
      check("ar_run2_iaddr", IAddr, 32'h4);

      // Random traffic, compared against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) == 0 || ((m_halt || m_fault) && $urandom_range(0, 9) == 0)) begin
            do_reset();
         end else begin
            PCWre = ($urandom_range(0, 3) != 0);
            PCSrc = 2'($urandom_range(0, 3));
            Immediate = 32'($urandom_range(0, 40)) - 32'd20;
            JumpAddr = 26'($urandom_range(0, 140));
            case ($urandom_range(0, 9))
               0:       RegJumpAddr = $urandom();
               1:       RegJumpAddr = 32'($urandom_range(0, 140)) * 32'd4 + 32'd2;
               default: RegJumpAddr = 32'($urandom_range(0, 135)) * 32'd4;
            endcase
            if ($urandom_range(0, 29) == 0)
               Instruction = {6'h3F, 26'($urandom())};
            else
               Instruction = {6'($urandom_range(0, 62)), 26'($urandom())};
            tick("rnd");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
